// File: rtl/cfg_tieoffs_loader_pkg.sv
// Shared types and constants for the card-info tie-off loader.
// Defines the ROM word map, the magic word and the loader FSM states.
package cfg_tieoffs_loader_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROM_WORDS = 5;

    localparam logic [ADDR_W-1:0] ADDR_MAGIC  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_IDS    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_SER_LO = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_SER_HI = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_CSUM   = ADDR_W'(ROM_WORDS - 1);

    localparam logic [DATA_W-1:0] ROM_MAGIC = 32'h4F43_4149;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Values read from the card-info ROM and driven into config space
    typedef struct packed {
        logic [15:0] vid;
        logic [15:0] id;
        logic [63:0] serial;
    } card_info_t;

endpackage

// File: rtl/cfg_tieoffs_rom_rd.sv
// ROM read handshake: holds rd_req from start until ack or timeout,
// and counts wait cycles so a silent ROM cannot stall config space forever.
module cfg_tieoffs_rom_rd #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic rd_ack,
    output logic rd_req,
    output logic ack_c,
    output logic timeout_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // Ack is only honoured while a request is outstanding
    assign ack_c     = rd_req & rd_ack;
    assign timeout_c = rd_req & ~rd_ack & (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_req <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            rd_req <= 1'b1;
            cnt    <= '0;
        end else if (rd_req) begin
            if (ack_c || timeout_c) begin
                rd_req <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cfg_tieoffs_loader.sv
// Loads subsystem IDs and DSN from the card-info ROM after reset or reload,
// validates magic and checksum, and falls back to defaults on any failure.
module cfg_tieoffs_loader
    import cfg_tieoffs_loader_pkg::*;
#(
    parameter int unsigned NUM_AFU        = 1,
    parameter logic [15:0] DEF_SUBSYS_ID  = 16'h0666,
    parameter logic [15:0] DEF_SUBSYS_VID = 16'h1014,
    parameter logic [63:0] DEF_SERIAL     = 64'hDEAD_DEAD_DEAD_DEAD,
    parameter int unsigned BAR0_SIZE_LOG2 = 32,
    parameter int unsigned PASID_WIDTH    = 9,
    parameter logic [11:0] ACTAG_LEN      = 12'h020,
    parameter int unsigned TIMEOUT_CYC    = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    reload,
    output logic                    rd_req,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_ack,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    cfg_ready,
    output logic                    load_err,
    output logic [15:0]             f0_ro_csh_subsystem_id,
    output logic [15:0]             f1_ro_csh_subsystem_id,
    output logic [15:0]             f0_ro_csh_subsystem_vendor_id,
    output logic [15:0]             f1_ro_csh_subsystem_vendor_id,
    output logic [63:0]             f0_ro_dsn_serial_number,
    output logic [63:0]             f1_ro_csh_mmio_bar0_size,
    output logic [4:0]              f1_ro_pasid_max_pasid_width,
    output logic [4:0]              f1_ro_ofunc_max_afu_index,
    output logic [NUM_AFU*6-1:0]    f1_ro_octrl_afu_control_index,
    output logic [NUM_AFU*5-1:0]    f1_ro_octrl_pasid_len_supported,
    output logic [NUM_AFU*12-1:0]   f1_ro_octrl_actag_len_supported
);

    localparam logic [63:0] BAR0_MASK = ~((64'd1 << BAR0_SIZE_LOG2) - 64'd1);
    localparam card_info_t  DEF_INFO  = '{vid: DEF_SUBSYS_VID, id: DEF_SUBSYS_ID, serial: DEF_SERIAL};

    state_e            state_q, state_d;
    logic              start_c, ack_c, timeout_c, load_ok_c;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] xor_q, xor_d, magic_q, magic_d;
    card_info_t        shadow_q, shadow_d, info_q, info_d;
    logic              cfg_ready_d, load_err_d;

    // Parameter-derived tie-offs
    assign f1_ro_csh_mmio_bar0_size    = BAR0_MASK;
    assign f1_ro_pasid_max_pasid_width = 5'(PASID_WIDTH);
    assign f1_ro_ofunc_max_afu_index   = 5'(NUM_AFU - 1);

    for (genvar i = 0; i < NUM_AFU; i++) begin : g_afu
        assign f1_ro_octrl_afu_control_index[i*6 +: 6]    = 6'(i);
        assign f1_ro_octrl_pasid_len_supported[i*5 +: 5]  = 5'(PASID_WIDTH);
        assign f1_ro_octrl_actag_len_supported[i*12 +: 12] = ACTAG_LEN;
    end

    assign f0_ro_csh_subsystem_id        = info_q.id;
    assign f1_ro_csh_subsystem_id        = info_q.id;
    assign f0_ro_csh_subsystem_vendor_id = info_q.vid;
    assign f1_ro_csh_subsystem_vendor_id = info_q.vid;
    assign f0_ro_dsn_serial_number       = info_q.serial;

    cfg_tieoffs_rom_rd #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rom_rd (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start_c),
        .rd_ack    (rd_ack),
        .rd_req    (rd_req),
        .ack_c     (ack_c),
        .timeout_c (timeout_c)
    );

    // Checksum word makes the running XOR of all five words zero
    assign load_ok_c = (magic_q == ROM_MAGIC) && (xor_q == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (ack_c) begin
                    state_d = (rd_addr == ADDR_CSUM) ? ST_CHECK : ST_REQ;
                end else if (timeout_c) begin
                    state_d = ST_ERR;
                end
            end
            ST_CHECK: state_d = load_ok_c ? ST_DONE : ST_ERR;
            ST_DONE,
            ST_ERR: begin
                if (reload) begin
                    state_d = ST_REQ;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_c     = 1'b0;
        rd_addr_d   = rd_addr;
        xor_d       = xor_q;
        magic_d     = magic_q;
        shadow_d    = shadow_q;
        info_d      = info_q;
        cfg_ready_d = cfg_ready;
        load_err_d  = load_err;
        case (state_q)
            ST_REQ: start_c = 1'b1;
            ST_WAIT: begin
                if (ack_c) begin
                    xor_d = xor_q ^ rd_data;
                    case (rd_addr)
                        ADDR_MAGIC: magic_d = rd_data;
                        ADDR_IDS: begin
                            shadow_d.vid = rd_data[31:16];
                            shadow_d.id  = rd_data[15:0];
                        end
                        ADDR_SER_LO: shadow_d.serial[31:0]  = rd_data;
                        ADDR_SER_HI: shadow_d.serial[63:32] = rd_data;
                        default: ;
                    endcase
                    if (rd_addr != ADDR_CSUM) begin
                        rd_addr_d = rd_addr + ADDR_W'(1);
                    end
                end else if (timeout_c) begin
                    info_d      = DEF_INFO;
                    cfg_ready_d = 1'b1;
                    load_err_d  = 1'b1;
                end
            end
            // Single-cycle commit so no partially loaded set is ever visible
            ST_CHECK: begin
                cfg_ready_d = 1'b1;
                if (load_ok_c) begin
                    info_d     = shadow_q;
                    load_err_d = 1'b0;
                end else begin
                    info_d     = DEF_INFO;
                    load_err_d = 1'b1;
                end
            end
            ST_DONE,
            ST_ERR: begin
                if (reload) begin
                    cfg_ready_d = 1'b0;
                    rd_addr_d   = '0;
                    xor_d       = '0;
                    magic_d     = '0;
                    shadow_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr   <= '0;
            xor_q     <= '0;
            magic_q   <= '0;
            shadow_q  <= '0;
            info_q    <= DEF_INFO;
            cfg_ready <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            rd_addr   <= rd_addr_d;
            xor_q     <= xor_d;
            magic_q   <= magic_d;
            shadow_q  <= shadow_d;
            info_q    <= info_d;
            cfg_ready <= cfg_ready_d;
            load_err  <= load_err_d;
        end
    end

endmodule

// File: tb/tb_cfg_tieoffs_loader.sv
// Directed bench for cfg_tieoffs_loader: ROM-image vector table plus
// hand-written reload, timeout, stray-ack and mid-load reset sequences.
module tb_cfg_tieoffs_loader;

    localparam int unsigned NUM_AFU     = 4;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam logic [15:0] DEF_ID      = 16'h0666;
    localparam logic [15:0] DEF_VID     = 16'h1014;
    localparam logic [63:0] DEF_SER     = 64'hDEAD_DEAD_DEAD_DEAD;

    logic                  clock = 1'b0;
    logic                  reset_n, reload, rd_req, rd_ack, cfg_ready, load_err;
    logic [2:0]            rd_addr;
    logic [31:0]           rd_data;
    logic [15:0]           f0_id, f1_id, f0_vid, f1_vid;
    logic [63:0]           f0_ser, bar0;
    logic [4:0]            pasid_w, max_afu;
    logic [NUM_AFU*6-1:0]  ctrl_idx;
    logic [NUM_AFU*5-1:0]  pasid_len;
    logic [NUM_AFU*12-1:0] actag_len;

    always #5 clock = ~clock;

    cfg_tieoffs_loader #(
        .NUM_AFU     (NUM_AFU),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock                           (clock),
        .reset_n                         (reset_n),
        .reload                          (reload),
        .rd_req                          (rd_req),
        .rd_addr                         (rd_addr),
        .rd_ack                          (rd_ack),
        .rd_data                         (rd_data),
        .cfg_ready                       (cfg_ready),
        .load_err                        (load_err),
        .f0_ro_csh_subsystem_id          (f0_id),
        .f1_ro_csh_subsystem_id          (f1_id),
        .f0_ro_csh_subsystem_vendor_id   (f0_vid),
        .f1_ro_csh_subsystem_vendor_id   (f1_vid),
        .f0_ro_dsn_serial_number         (f0_ser),
        .f1_ro_csh_mmio_bar0_size        (bar0),
        .f1_ro_pasid_max_pasid_width     (pasid_w),
        .f1_ro_ofunc_max_afu_index       (max_afu),
        .f1_ro_octrl_afu_control_index   (ctrl_idx),
        .f1_ro_octrl_pasid_len_supported (pasid_len),
        .f1_ro_octrl_actag_len_supported (actag_len)
    );

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] csum_mask;
        int          stall;
        bit          exp_err;
        logic [15:0] id, vid;
        logic [63:0] ser;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] rom [5];
    int          stall_addr = -1;
    logic        spur = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Zero-wait ROM: acks in the first cycle rd_req is seen high, one-cycle pulse
    always @(negedge clock) begin
        if (rd_ack) begin
            rd_ack = 1'b0;
        end else if (spur) begin
            rd_ack  = 1'b1;
            rd_data = 32'hFFFF_FFFF;
        end else if (rd_req && int'(rd_addr) != stall_addr) begin
            rd_ack  = 1'b1;
            rd_data = rom[rd_addr];
        end
    end

    // Counts cycles where outputs move away from the held set before cfg_ready
    logic        watch = 1'b0;
    logic [15:0] hold_id, hold_vid;
    logic [63:0] hold_ser;
    int          bad = 0;
    always @(negedge clock) begin
        if (watch && !cfg_ready &&
            (f0_id !== hold_id || f1_id !== hold_id || f0_vid !== hold_vid ||
             f1_vid !== hold_vid || f0_ser !== hold_ser)) begin
            bad++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        reload  = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output int cyc);
        cyc = 0;
        while (!cfg_ready && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_addr(input logic [2:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd_req && rd_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_rom(input vec_t v);
        rom[0] = v.w0;
        rom[1] = v.w1;
        rom[2] = v.w2;
        rom[3] = v.w3;
        rom[4] = v.w0 ^ v.w1 ^ v.w2 ^ v.w3 ^ v.csum_mask;
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
    endtask

    initial begin
        int cyc, n, bad_base;
        bit ok;
        logic [NUM_AFU*6-1:0] exp_ctrl;

        reset_n = 1'b0;
        reload  = 1'b0;
        rd_ack  = 1'b0;
        rd_data = '0;

        vecs[0] = '{32'h4F43_4149, 32'h1014_1234, 32'hCAFE_F00D, 32'h0123_4567, 32'h0, -1, 1'b0,
                    16'h1234, 16'h1014, 64'h0123_4567_CAFE_F00D};
        vecs[1] = '{32'h0000_0000, 32'h1014_1234, 32'hCAFE_F00D, 32'h0123_4567, 32'h0, -1, 1'b1,
                    DEF_ID, DEF_VID, DEF_SER};
        vecs[2] = '{32'h4F43_4149, 32'h1014_1234, 32'hCAFE_F00D, 32'h0123_4567, 32'h1, -1, 1'b1,
                    DEF_ID, DEF_VID, DEF_SER};
        vecs[3] = '{32'h4F43_4149, 32'h1014_1234, 32'hCAFE_F00D, 32'h0123_4567, 32'h0, 2, 1'b1,
                    DEF_ID, DEF_VID, DEF_SER};
        vecs[4] = '{32'h4F43_4149, 32'hABCD_5678, 32'h1111_2222, 32'h3333_4444, 32'h0, -1, 1'b0,
                    16'h5678, 16'hABCD, 64'h3333_4444_1111_2222};
        vecs[5] = '{32'h4F43_4148, 32'h1014_1234, 32'hCAFE_F00D, 32'h0123_4567, 32'h0, -1, 1'b1,
                    DEF_ID, DEF_VID, DEF_SER};

        // Reset state and parameter tie-offs
        load_rom(vecs[0]);
        repeat (2) @(negedge clock);
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_ids", 64'({f0_id, f1_id, f0_vid, f1_vid}), {DEF_ID, DEF_ID, DEF_VID, DEF_VID});
        check("rst_serial", f0_ser, DEF_SER);
        check("bar0", bar0, 64'hFFFF_FFFF_0000_0000);
        check("pasid_width", 64'(pasid_w), 64'd9);
        check("max_afu_index", 64'(max_afu), 64'd3);
        exp_ctrl = {6'd3, 6'd2, 6'd1, 6'd0};
        check("ctrl_index", 64'(ctrl_idx), 64'(exp_ctrl));
        check("pasid_len", 64'(pasid_len), 64'({4{5'd9}}));
        check("actag_len", 64'(actag_len), 64'({4{12'h020}}));

        // Zero-wait ROM latency from reset release
        @(negedge clock);
        reset_n = 1'b1;
        wait_ready(40, cyc);
        checks++;
        if (!(cfg_ready && cyc <= 12)) begin
            failures++;
            $display("FAIL latency cycles=%0d cfg_ready=%0b required<=12 and 1", cyc, cfg_ready);
        end

        // ROM image table
        foreach (vecs[k]) begin
            load_rom(vecs[k]);
            stall_addr = vecs[k].stall;
            hold_id    = DEF_ID;
            hold_vid   = DEF_VID;
            hold_ser   = DEF_SER;
            apply_reset();
            bad_base = bad;
            watch    = 1'b1;
            wait_ready(80, cyc);
            watch    = 1'b0;
            stall_addr = -1;
            check($sformatf("v%0d_cfg_ready", k), 64'(cfg_ready), 64'd1);
            check($sformatf("v%0d_load_err", k), 64'(load_err), 64'(vecs[k].exp_err));
            check($sformatf("v%0d_id", k), 64'({f0_id, f1_id}), 64'({vecs[k].id, vecs[k].id}));
            check($sformatf("v%0d_vid", k), 64'({f0_vid, f1_vid}), 64'({vecs[k].vid, vecs[k].vid}));
            check($sformatf("v%0d_serial", k), f0_ser, vecs[k].ser);
            check($sformatf("v%0d_no_transient", k), 64'(bad - bad_base), 64'd0);
        end

        // Timeout: no ack at word 2
        load_rom(vecs[0]);
        stall_addr = 2;
        apply_reset();
        wait_addr(3'd2, ok);
        check("to_req_seen", 64'(ok), 64'd1);
        n = 0;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 64'(n), 64'd16);
        check("to_rd_req_drop", 64'(rd_req), 64'd0);
        check("to_load_err", 64'(load_err), 64'd1);
        stall_addr = -1;

        // Reload from DONE: old values held, reload inside WAIT ignored
        apply_reset();
        wait_ready(80, cyc);
        check("rl_first_done", 64'({cfg_ready, f0_id}), 64'({1'b1, 16'h1234}));
        load_rom(vecs[4]);
        hold_id    = 16'h1234;
        hold_vid   = 16'h1014;
        hold_ser   = 64'h0123_4567_CAFE_F00D;
        bad_base   = bad;
        watch      = 1'b1;
        stall_addr = 1;
        pulse_reload();
        check("rl_ready_drop", 64'(cfg_ready), 64'd0);
        wait_addr(3'd1, ok);
        check("rl_wait_seen", 64'(ok), 64'd1);
        pulse_reload();
        tick();
        check("rl_ignored_in_wait", 64'({rd_req, rd_addr, cfg_ready}), 64'({1'b1, 3'd1, 1'b0}));
        stall_addr = -1;
        wait_ready(80, cyc);
        watch = 1'b0;
        check("rl_new_ids", 64'({cfg_ready, load_err, f0_id, f0_vid}), 64'({1'b1, 1'b0, 16'h5678, 16'hABCD}));
        check("rl_new_serial", f0_ser, 64'h3333_4444_1111_2222);
        check("rl_held_old", 64'(bad - bad_base), 64'd0);

        // Stray ack while DONE must not disturb anything
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (2) tick();
        check("stray_ack", 64'({cfg_ready, rd_req, rd_addr, f0_id, f0_vid}),
              64'({1'b1, 1'b0, 3'd4, 16'h5678, 16'hABCD}));

        // Reset in the middle of a reload
        pulse_reload();
        wait_addr(3'd3, ok);
        check("mr_word3_seen", 64'(ok), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mr_ctrl", 64'({cfg_ready, load_err, rd_req, rd_addr}), 64'd0);
        check("mr_ids", 64'({f0_id, f0_vid}), 64'({DEF_ID, DEF_VID}));
        check("mr_serial", f0_ser, DEF_SER);
        repeat (3) @(negedge clock);
        check("mr_hold_in_reset", 64'(cfg_ready), 64'd0);
        reset_n = 1'b1;
        wait_ready(80, cyc);
        check("mr_reload_ok", 64'({cfg_ready, load_err, f0_id}), 64'({1'b1, 1'b0, 16'h5678}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
